// File: rtl/s2_arb_pkg.sv
// Shared types and constants for the S2 round-robin arbiter.
// Select codes name which source word an S2 instance forwards.
package s2_arb_pkg;

  localparam int NREQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  localparam logic [1:0] SEL_D00 = 2'b00;
  localparam logic [1:0] SEL_D01 = 2'b01;
  localparam logic [1:0] SEL_D10 = 2'b10;
  localparam logic [1:0] SEL_D11 = 2'b11;

  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/s2_rr_pick.sv
// Combinational rotate-priority picker: scans req starting at ptr and
// returns the index of the first set bit, plus whether any bit was set.
module s2_rr_pick
  import s2_arb_pkg::*;
(
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [1:0] o_grant,
  output logic       o_any
);

  logic [1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Two-bit add wraps 3 -> 0, giving the modular search order.
      w_idx = i_ptr + k[1:0];
      if (!o_any && i_req[w_idx]) begin
        o_grant = w_idx;
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/s2_rr_arbiter.sv
// Round-robin arbiter and output sequencer: picks one of four source words,
// holds it in out with a valid/ready handshake, and mirrors the S2 select.
module s2_rr_arbiter
  import s2_arb_pkg::*;
#(
  parameter int size = 5
) (
  input  logic            clk,
  input  logic            CLR,
  input  logic [3:0]      req,
  input  logic [size-1:0] D00,
  input  logic [size-1:0] D01,
  input  logic [size-1:0] D10,
  input  logic [size-1:0] D11,
  input  logic            out_ready,
  output logic [size-1:0] out,
  output logic            out_valid,
  output logic [3:0]      ack,
  output logic            A1,
  output logic            B1,
  output logic            A0,
  output logic            B0,
  output logic            busy,
  output logic            o_dbg_state,
  output logic [1:0]      o_dbg_ptr
);

  // Handshake: out is transferred on any edge where out_valid & out_ready.
  // A new word may be captured on that same edge (no bubble), or whenever
  // nothing is held. ack is the source-side handshake: one-hot, same cycle.

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_ptr;
  logic [1:0]      r_sel;
  logic [size-1:0] r_out;
  logic            r_out_valid;

  logic [1:0]      w_grant;
  logic            w_any;
  logic            w_cap_en;
  logic            w_cap;
  logic [size-1:0] w_word;

  s2_rr_pick u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  assign w_cap_en = (r_state == IDLE) | out_ready;
  assign w_cap    = w_cap_en & w_any & ~CLR;

  always_comb begin
    w_word = D00;
    case (w_grant)
      SEL_D00: w_word = D00;
      SEL_D01: w_word = D01;
      SEL_D10: w_word = D10;
      SEL_D11: w_word = D11;
      default: w_word = D00;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cap) w_state_nxt = VALID;
      VALID:   if (out_ready && !w_cap) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (CLR) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Selects and ptr move only on capture; an accept alone leaves them.
  always_ff @(posedge clk) begin
    if (CLR) begin
      r_ptr       <= '0;
      r_sel       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_cap) begin
      r_ptr       <= w_grant + 2'd1;
      r_sel       <= w_grant;
      r_out       <= w_word;
      r_out_valid <= 1'b1;
    end else if (r_state == VALID && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign ack         = w_cap ? onehot4(w_grant) : 4'b0000;
  assign out         = r_out;
  assign out_valid   = r_out_valid;
  assign busy        = r_out_valid;
  assign A1          = r_sel[1];
  assign B1          = r_sel[1];
  assign A0          = r_sel[0];
  assign B0          = r_sel[0];
  assign o_dbg_state = r_state;
  assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_s2_rr_arbiter.sv
// Directed bench for s2_rr_arbiter: reset, single grant, rotation,
// backpressure, drain and reset during a held word.
module tb_s2_rr_arbiter;

  logic       clk;
  logic       CLR;
  logic [3:0] req;
  logic [4:0] D00, D01, D10, D11;
  logic       out_ready;
  logic [4:0] out;
  logic       out_valid;
  logic [3:0] ack;
  logic       A1, B1, A0, B0;
  logic       busy;
  logic       dbg_state;
  logic [1:0] dbg_ptr;

  int n_cmp;
  int n_err;

  s2_rr_arbiter #(.size(5)) dut (
    .clk         (clk),
    .CLR         (CLR),
    .req         (req),
    .D00         (D00),
    .D01         (D01),
    .D10         (D10),
    .D11         (D11),
    .out_ready   (out_ready),
    .out         (out),
    .out_valid   (out_valid),
    .ack         (ack),
    .A1          (A1),
    .B1          (B1),
    .A0          (A0),
    .B0          (B0),
    .busy        (busy),
    .o_dbg_state (dbg_state),
    .o_dbg_ptr   (dbg_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are
  // sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag, input logic [4:0] e_out, input logic e_valid,
                          input logic [3:0] e_sel);
    chk({tag, ".out"}, out, e_out);
    chk({tag, ".valid"}, out_valid, e_valid);
    chk({tag, ".busy"}, busy, e_valid);
    chk({tag, ".sel"}, {A1, B1, A0, B0}, e_sel);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    CLR = 1'b1; req = 4'b0000; out_ready = 1'b0;
    D00 = 5'h01; D01 = 5'h0A; D10 = 5'h15; D11 = 5'h1E;

    // Reset
    tick(); tick();
    chk_regs("rst", 5'h00, 1'b0, 4'b0000);
    chk("rst.ack", ack, 4'b0000);
    chk("rst.state", dbg_state, 1'b0);
    chk("rst.ptr", dbg_ptr, 2'd0);

    // Single request from D10
    CLR = 1'b0; req = 4'b0100; out_ready = 1'b1;
    #1 chk("single.ack", ack, 4'b0100);
    tick();
    req = 4'b0000;
    chk_regs("single", 5'h15, 1'b1, 4'b1100);
    chk("single.ptr", dbg_ptr, 2'd3);
    tick();
    chk_regs("single_drain", 5'h15, 1'b0, 4'b1100);

    // Round robin from ptr=0 with all requests held
    CLR = 1'b1;
    tick();
    CLR = 1'b0; req = 4'b1111; out_ready = 1'b1;
    #1 chk("rr0.ack", ack, 4'b0001);
    tick();
    chk_regs("rr0", 5'h01, 1'b1, 4'b0000);
    chk("rr1.ack", ack, 4'b0010);
    tick();
    chk_regs("rr1", 5'h0A, 1'b1, 4'b0011);
    chk("rr2.ack", ack, 4'b0100);
    tick();
    chk_regs("rr2", 5'h15, 1'b1, 4'b1100);
    chk("rr3.ack", ack, 4'b1000);
    tick();
    chk_regs("rr3", 5'h1E, 1'b1, 4'b1111);
    chk("rr4.ack", ack, 4'b0001);
    tick();
    chk_regs("rr4", 5'h01, 1'b1, 4'b0000);
    chk("rr4.ptr", dbg_ptr, 2'd1);
    req = 4'b0000; out_ready = 1'b0;
    tick();
    chk_regs("hold_idle_req", 5'h01, 1'b1, 4'b0000);

    // Backpressure: capture D01, then stall with req=1001
    req = 4'b0010; out_ready = 1'b1;
    #1 chk("bp_cap.ack", ack, 4'b0010);
    tick();
    chk_regs("bp_cap", 5'h0A, 1'b1, 4'b0011);
    req = 4'b1001; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_stall.ack", ack, 4'b0000);
      tick();
      chk_regs("bp_stall", 5'h0A, 1'b1, 4'b0011);
    end
    out_ready = 1'b1;
    #1 chk("bp_release.ack", ack, 4'b1000);
    tick();
    chk_regs("bp_release", 5'h1E, 1'b1, 4'b1111);
    chk("bp_release.ptr", dbg_ptr, 2'd0);

    // Drain: accept with no request returns to IDLE, out holds
    req = 4'b0000;
    #1 chk("drain.ack", ack, 4'b0000);
    tick();
    chk_regs("drain", 5'h1E, 1'b0, 4'b1111);
    chk("drain.state", dbg_state, 1'b0);
    tick();
    chk_regs("idle_hold", 5'h1E, 1'b0, 4'b1111);

    // Reset while holding 5'h1F
    D11 = 5'h1F; req = 4'b1000;
    #1 chk("mid_cap.ack", ack, 4'b1000);
    tick();
    req = 4'b0000; out_ready = 1'b0;
    chk_regs("mid_cap", 5'h1F, 1'b1, 4'b1111);
    CLR = 1'b1; req = 4'b0001; out_ready = 1'b1;
    #1 chk("mid_clr.ack", ack, 4'b0000);
    tick();
    chk_regs("mid_clr", 5'h00, 1'b0, 4'b0000);
    chk("mid_clr.ptr", dbg_ptr, 2'd0);
    chk("mid_clr.state", dbg_state, 1'b0);
    CLR = 1'b0;
    #1 chk("post_clr.ack", ack, 4'b0001);
    tick();
    chk_regs("post_clr", 5'h01, 1'b1, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
